// File: rtl/cam_controller.sv
`default_nettype none
// ============================================================================
// Module   : cam_controller
// Purpose  : Command sequencer for a CAM_Wrapper datapath. Accepts single-beat
//            SEARCH / WRITE / INVALIDATE / CLEAR commands, drives the CAM
//            inputs for one cycle (or pulses the CAM reset for CLEAR), waits
//            out the CAM pipeline latency, masks the returned match vector with
//            a per-row valid bitmap and returns a priority-encoded response.
// Ports    : clk, rst (sync, active high)
//            cmd_valid/cmd_ready/cmd_op/cmd_row/cmd_data/cmd_mask - command in
//            rsp_valid/rsp_ready/rsp_hit/rsp_index/rsp_multi/rsp_err - response
//            cam_rst, cam_we_decoded_row_address, cam_search_word,
//            cam_dont_care_mask - registered drive to CAM_Wrapper
//            cam_decoded_match_address - match vector from CAM_Wrapper
// Options  : define CAM_CTRL_MULTIHIT_EN to build multiple-hit detection
//            (rsp_multi); otherwise rsp_multi is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module cam_controller #(
  parameter int CAM_DEPTH   = 8,
  parameter int CAM_WIDTH   = 8,
  parameter int CAM_LATENCY = 2,
  parameter int ADDR_W      = $clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_row,
  input  logic [CAM_WIDTH-1:0] cmd_data,
  input  logic [CAM_WIDTH-1:0] cmd_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [ADDR_W-1:0]    rsp_index,
  output logic                 rsp_multi,
  output logic                 rsp_err,
  output logic                 cam_rst,
  output logic [CAM_DEPTH-1:0] cam_we_decoded_row_address,
  output logic [CAM_WIDTH-1:0] cam_search_word,
  output logic [CAM_WIDTH-1:0] cam_dont_care_mask,
  input  logic [CAM_DEPTH-1:0] cam_decoded_match_address
);

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  // Counter must hold CAM_LATENCY+1: CLEAR spends one extra cycle after the
  // CAM reset pulse so that every op has the same accept-to-response latency.
  localparam int                   CNT_W   = $clog2(CAM_LATENCY + 2);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_TWO = CNT_W'(2);
  localparam logic [CAM_DEPTH-1:0] ROW0_OH = CAM_DEPTH'(1);
  localparam logic [31:0]          DEPTH32 = 32'(CAM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    CLR   = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           op_q;
  logic                 err_q;
  logic [CAM_DEPTH-1:0] row_oh_q;
  logic [CAM_DEPTH-1:0] valid_bits;

  logic                 accept;
  logic                 row_ok;
  logic [CAM_DEPTH-1:0] row_oh;
  logic [CAM_DEPTH-1:0] masked;
  logic [ADDR_W-1:0]    enc_index;
  logic                 capture;

  assign accept  = cmd_valid && cmd_ready;
  assign row_ok  = ({{(32-ADDR_W){1'b0}}, cmd_row} < DEPTH32);
  // Out-of-range rows shift the single bit off the top, giving all zeros.
  assign row_oh  = ROW0_OH << cmd_row;
  // Rows that were never written or were invalidated may still hold stale
  // data inside the CAM, so only rows marked valid are allowed to hit.
  assign masked  = cam_decoded_match_address & valid_bits;
  assign capture = (state == WAIT) && (cnt == CNT_ONE);

  // Lowest set bit wins: scan from the top so the lowest index is written last.
  always_comb begin
    enc_index = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (masked[i]) enc_index = ADDR_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (cmd_op == OP_CLEAR) ? CLR : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == CNT_ONE) state_nxt = RESP;
      CLR:     if (cnt == CNT_ONE) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= IDLE;
      cmd_ready                  <= 1'b0;
      cnt                        <= '0;
      op_q                       <= OP_SEARCH;
      err_q                      <= 1'b0;
      row_oh_q                   <= '0;
      valid_bits                 <= '0;
      rsp_valid                  <= 1'b0;
      rsp_hit                    <= 1'b0;
      rsp_index                  <= '0;
      rsp_err                    <= 1'b0;
      cam_rst                    <= 1'b1;
      cam_we_decoded_row_address <= '0;
      cam_search_word            <= '0;
      cam_dont_care_mask         <= '0;
    end else begin
      state                      <= state_nxt;
      cmd_ready                  <= (state_nxt == IDLE);
      rsp_valid                  <= (state_nxt == RESP);
      cam_we_decoded_row_address <= '0;
      cam_rst                    <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            err_q    <= ((cmd_op == OP_WRITE) || (cmd_op == OP_INVAL)) && !row_ok;
            row_oh_q <= row_ok ? row_oh : '0;
            // CAM inputs are registered, so they are loaded here to be
            // present during the ISSUE cycle.
            if ((cmd_op == OP_SEARCH) || ((cmd_op == OP_WRITE) && row_ok)) begin
              cam_search_word    <= cmd_data;
              cam_dont_care_mask <= cmd_mask;
            end
            if ((cmd_op == OP_WRITE) && row_ok) begin
              cam_we_decoded_row_address <= row_oh;
            end
            if (cmd_op == OP_CLEAR) begin
              cnt     <= CNT_W'(CAM_LATENCY + 1);
              cam_rst <= 1'b1;
            end
          end
        end

        ISSUE: begin
          cnt <= CNT_W'(CAM_LATENCY);
          if (!err_q) begin
            if (op_q == OP_WRITE) valid_bits <= valid_bits | row_oh_q;
            if (op_q == OP_INVAL) valid_bits <= valid_bits & ~row_oh_q;
          end
        end

        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (capture) begin
            rsp_hit   <= (op_q == OP_SEARCH) && (|masked);
            rsp_index <= (op_q == OP_SEARCH) ? enc_index : '0;
            rsp_err   <= err_q;
          end
        end

        CLR: begin
          cnt        <= cnt - CNT_ONE;
          valid_bits <= '0;
          // Keeps the CAM reset high for the first CAM_LATENCY CLR cycles.
          cam_rst    <= (cnt > CNT_TWO);
          if (cnt == CNT_ONE) begin
            rsp_hit   <= 1'b0;
            rsp_index <= '0;
            rsp_err   <= 1'b0;
          end
        end

        RESP: begin
        end

        default: begin
        end
      endcase
    end
  end

`ifdef CAM_CTRL_MULTIHIT_EN
  logic many_hits;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign many_hits = |(masked & (masked - ROW0_OH));

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_multi <= 1'b0;
    end else if (capture) begin
      rsp_multi <= (op_q == OP_SEARCH) && many_hits;
    end else if ((state == CLR) && (cnt == CNT_ONE)) begin
      rsp_multi <= 1'b0;
    end
  end
`else
  assign rsp_multi = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_controller
// Purpose  : Self-checking bench for cam_controller. A simple CAM with a
//            CAM_LATENCY-deep match pipeline stands in for CAM_Wrapper; a
//            command-level model (row words + valid flags) predicts every
//            output on every cycle, and directed commands add literal checks.
//            Honours CAM_CTRL_MULTIHIT_EN for the rsp_multi expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_controller;

  localparam int L  = 2;
  localparam int D  = 8;
  localparam int W  = 8;
  localparam int AW = 4;

`ifdef CAM_CTRL_MULTIHIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  localparam logic [1:0] SEARCH = 2'b00;
  localparam logic [1:0] WRITE  = 2'b01;
  localparam logic [1:0] INVAL  = 2'b10;
  localparam logic [1:0] CLEAR  = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_row = '0;
  logic [W-1:0]  cmd_data = '0;
  logic [W-1:0]  cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_hit;
  logic [AW-1:0] rsp_index;
  logic          rsp_multi;
  logic          rsp_err;
  logic          cam_rst;
  logic [D-1:0]  cam_we;
  logic [W-1:0]  cam_word;
  logic [W-1:0]  cam_mask;
  logic [D-1:0]  match_vec;

  cam_controller #(
    .CAM_DEPTH(D), .CAM_WIDTH(W), .CAM_LATENCY(L), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_index(rsp_index), .rsp_multi(rsp_multi), .rsp_err(rsp_err),
    .cam_rst(cam_rst), .cam_we_decoded_row_address(cam_we),
    .cam_search_word(cam_word), .cam_dont_care_mask(cam_mask),
    .cam_decoded_match_address(match_vec)
  );

  always #5 clk = ~clk;

  // ---------------- CAM stand-in ----------------
  // Storage survives cam_rst on purpose: stale rows can then only be hidden
  // by the controller's own valid bookkeeping.
  logic [W-1:0] cam_mem [D];
  logic [D-1:0] pipe    [L];
  logic [D-1:0] match_now;

  initial begin
    for (int r = 0; r < D; r++) cam_mem[r] = '0;
    for (int k = 0; k < L; k++) pipe[k] = '0;
  end

  always_comb begin
    match_now = '0;
    for (int r = 0; r < D; r++)
      match_now[r] = (((cam_mem[r] ^ cam_word) & ~cam_mask) == '0);
  end

  always @(posedge clk) begin
    for (int r = 0; r < D; r++) if (cam_we[r]) cam_mem[r] <= cam_word;
    pipe[0] <= match_now;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end

  assign match_vec = pipe[L-1];

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command-level model.
  logic [W-1:0] m_word [D];
  bit           m_val  [D];
  int           age = -1;     // -1 idle, else cycles since accept
  bit           rst_prev = 1'b1;
  logic [1:0]   e_op = 2'b00;
  bit           e_hit, e_multi, e_err;
  int           e_idx;
  logic [D-1:0] e_we;
  logic [W-1:0] cur_word = '0;
  logic [W-1:0] cur_mask = '0;

  task automatic model_accept();
    int  row;
    bit  legal;
    int  n;
    row   = int'(cmd_row);
    legal = row < D;
    e_op  = cmd_op;
    e_err = ((cmd_op == WRITE) || (cmd_op == INVAL)) && !legal;
    e_we  = '0;
    if (cmd_op == WRITE && legal) e_we = D'(1) << row;
    if (cmd_op == SEARCH || (cmd_op == WRITE && legal)) begin
      cur_word = cmd_data;
      cur_mask = cmd_mask;
    end
    e_hit = 1'b0; e_idx = 0; n = 0;
    if (cmd_op == SEARCH) begin
      for (int r = 0; r < D; r++) begin
        if (m_val[r] && (((m_word[r] ^ cmd_data) & ~cmd_mask) == '0)) begin
          if (!e_hit) e_idx = r;
          e_hit = 1'b1;
          n++;
        end
      end
    end
    e_multi = MULTI && (n > 1);
    if (cmd_op == WRITE && legal) begin m_val[row] = 1'b1; m_word[row] = cmd_data; end
    if (cmd_op == INVAL && legal) m_val[row] = 1'b0;
    if (cmd_op == CLEAR) for (int r = 0; r < D; r++) m_val[r] = 1'b0;
    age = 1;
  endtask

  initial for (int r = 0; r < D; r++) begin m_val[r] = 1'b0; m_word[r] = '0; end

  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst cmd_ready", cmd_ready, 0);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_hit", rsp_hit, 0);
      chk("rst rsp_index", rsp_index, 0);
      chk("rst rsp_multi", rsp_multi, 0);
      chk("rst rsp_err", rsp_err, 0);
      chk("rst cam_we", cam_we, 0);
      chk("rst cam_word", cam_word, 0);
      chk("rst cam_mask", cam_mask, 0);
      chk("rst cam_rst", cam_rst, 1);
    end else if (age < 0) begin
      chk("idle cmd_ready", cmd_ready, 1);
      chk("idle rsp_valid", rsp_valid, 0);
      chk("idle cam_we", cam_we, 0);
      chk("idle cam_rst", cam_rst, 0);
      chk("idle cam_word", cam_word, cur_word);
      chk("idle cam_mask", cam_mask, cur_mask);
    end else begin
      chk("busy cmd_ready", cmd_ready, 0);
      chk("cam_we", cam_we, (age == 1) ? e_we : '0);
      chk("cam_rst", cam_rst, (e_op == CLEAR) && (age <= L));
      chk("cam_word", cam_word, cur_word);
      chk("cam_mask", cam_mask, cur_mask);
      chk("rsp_valid", rsp_valid, age >= 2 + L);
      if (age >= 2 + L) begin
        chk("rsp_hit", rsp_hit, e_hit);
        chk("rsp_index", rsp_index, e_idx);
        chk("rsp_multi", rsp_multi, e_multi);
        chk("rsp_err", rsp_err, e_err);
      end
    end

    if (rst) begin
      age = -1;
      cur_word = '0;
      cur_mask = '0;
      for (int r = 0; r < D; r++) m_val[r] = 1'b0;
    end else if (!rst_prev) begin
      if (age < 0) begin
        if (cmd_valid && cmd_ready) model_accept();
      end else if (age >= 2 + L && rsp_ready) begin
        age = -1;
      end else begin
        age++;
      end
    end
    rst_prev = rst;
  end

  // ---------------- driver ----------------
  logic          r_hit, r_multi, r_err;
  logic [AW-1:0] r_idx;
  int            r_lat;

  task automatic send(input logic [1:0] op, input logic [AW-1:0] row,
                      input logic [W-1:0] data, input logic [W-1:0] mask);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_data = data; cmd_mask = mask;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept timeout: cmd_ready %0b after %0d cycles, expected 1", cmd_ready, n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int stall);
    int c, held;
    bit done;
    c = 1; held = 0; done = 1'b0; r_lat = 0;
    rsp_ready = (stall == 0);
    while (!done && c < 200) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (r_lat == 0) r_lat = c;
        if (rsp_ready) begin
          r_hit = rsp_hit; r_idx = rsp_index; r_multi = rsp_multi; r_err = rsp_err;
          done = 1'b1;
        end else begin
          held++;
          if (held >= stall) begin @(posedge clk); #1; rsp_ready = 1'b1; end
        end
      end
      c++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL response timeout: rsp_valid %0b after %0d cycles, expected 1", rsp_valid, c);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] row,
                        input logic [W-1:0] data, input logic [W-1:0] mask, input int stall);
    send(op, row, data, mask);
    wait_rsp(stall);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    do_cmd(WRITE, 4'd3, 8'hA5, 8'h00, 0);
    chk("lit write3 err", r_err, 0);
    chk("lit write3 latency", r_lat, 4);
    do_cmd(SEARCH, 4'd0, 8'hA5, 8'h00, 0);
    chk("lit searchA5 hit", r_hit, 1);
    chk("lit searchA5 index", r_idx, 3);
    chk("lit searchA5 latency", r_lat, 4);

    do_cmd(WRITE, 4'd2, 8'h3C, 8'h00, 0);
    do_cmd(WRITE, 4'd5, 8'h3C, 8'h00, 0);
    do_cmd(SEARCH, 4'd0, 8'h3C, 8'h00, 0);
    chk("lit search3C index", r_idx, 2);
    chk("lit search3C multi", r_multi, MULTI);

    do_cmd(INVAL, 4'd2, 8'h00, 8'h00, 0);
    do_cmd(SEARCH, 4'd0, 8'h3C, 8'h00, 0);
    chk("lit inval index", r_idx, 5);
    chk("lit inval multi", r_multi, 0);

    do_cmd(SEARCH, 4'd0, 8'hA0, 8'h0F, 0);
    chk("lit masked index", r_idx, 3);

    do_cmd(CLEAR, 4'd0, 8'h00, 8'h00, 0);
    chk("lit clear latency", r_lat, 4);
    do_cmd(SEARCH, 4'd0, 8'h3C, 8'h00, 0);
    chk("lit post-clear hit", r_hit, 0);

    do_cmd(WRITE, 4'd9, 8'h11, 8'h00, 0);
    chk("lit row9 err", r_err, 1);
    do_cmd(INVAL, 4'd8, 8'h00, 8'h00, 0);
    chk("lit row8 err", r_err, 1);
    do_cmd(SEARCH, 4'd0, 8'h00, 8'h00, 0);
    chk("lit empty hit", r_hit, 0);

    do_cmd(WRITE, 4'd7, 8'h5A, 8'h00, 0);
    do_cmd(SEARCH, 4'd0, 8'h5A, 8'h00, 10);
    chk("lit stall hit", r_hit, 1);
    chk("lit stall index", r_idx, 7);

    do_cmd(WRITE, 4'd1, 8'h77, 8'h00, 0);
    send(SEARCH, 4'd0, 8'h77, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    do_cmd(SEARCH, 4'd0, 8'h77, 8'h00, 0);
    chk("lit post-reset hit", r_hit, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
